// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional 16-bit completed-frame counter enabled by defining TX_ARB_FRAME_CNT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 3,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_tx_start,
  input  logic                 uart_tx_empty,
  input  logic                 cts,
  output logic                 rts,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 err_launch
`ifdef TX_ARB_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_count
`endif
);

  // state      | meaning
  // IDLE       | waiting for a request with cts and an idle transmitter
  // LAUNCH     | one-cycle start strobe to uart_tx
  // WAIT_START | waiting for uart_tx to report busy, bounded by START_TIMEOUT
  // WAIT_DONE  | frame in flight, waiting for uart_tx to go empty again
  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_q;
  logic [3:0]       cnt_q;
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]  off;
  logic [ID_W:0]    sum;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  rr_nxt;
  logic             grant_ok;
  logic             start_to;

  // Rotate so the rr pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> rr_q);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i[ID_W-1:0];
    end
    sum     = {1'b0, rr_q} + {1'b0, off};
    win_idx = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
    rr_nxt  = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  assign grant_ok  = (state_q == S_IDLE) && (|req_valid) && cts && uart_tx_empty;
  assign req_ready = grant_ok ? (NUM_REQ'(1) << win_idx) : '0;
  assign start_to  = (state_q == S_WAIT_START) && uart_tx_empty &&
                     ((cnt_q + 4'd1) == 4'(START_TIMEOUT));
  assign rts       = (|req_valid) || (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    uart_tx_start = 1'b0;
    busy          = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:       if (grant_ok) state_d = S_LAUNCH;
      S_LAUNCH: begin
        uart_tx_start = 1'b1;
        state_d       = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!uart_tx_empty) state_d = S_WAIT_DONE;
        else if (start_to)  state_d = S_IDLE;
      end
      S_WAIT_DONE:  if (uart_tx_empty) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      uart_data  <= '0;
      grant_id   <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      err_launch <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_ok) begin
        uart_data <= req_data[{win_idx, 3'b000} +: 8];
        grant_id  <= win_idx;
        rr_q      <= rr_nxt;
      end
      if (state_q == S_LAUNCH) cnt_q <= '0;
      else if (state_q == S_WAIT_START && uart_tx_empty) cnt_q <= cnt_q + 4'd1;
      if (start_to) err_launch <= 1'b1;
    end
  end

`ifdef TX_ARB_FRAME_CNT_EN
  // Only frames that actually went out are counted; timed-out launches are not.
  always_ff @(posedge baud_clk) begin
    if (rst) frame_count <= '0;
    else if (state_q == S_WAIT_DONE && uart_tx_empty) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple bit-serial uart_tx model.
// Frame-count checks are active when TX_ARB_FRAME_CNT_EN is defined.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           baud_clk  = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic           cts       = 1'b1;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_data;
  logic           uart_tx_start;
  logic           uart_tx_empty;
  logic           rts;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err_launch;
`ifdef TX_ARB_FRAME_CNT_EN
  logic [15:0]    frame_count;
`endif

  int tests = 0;
  int fails = 0;

  logic       tx_dead = 1'b0;
  logic [9:0] sh;
  logic [3:0] nleft;
  logic [9:0] rx_frame;
  logic       tx_line;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(3)) dut (
    .baud_clk      (baud_clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .uart_data     (uart_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_empty (uart_tx_empty),
    .cts           (cts),
    .rts           (rts),
    .grant_id      (grant_id),
    .busy          (busy),
    .err_launch    (err_launch)
`ifdef TX_ARB_FRAME_CNT_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  always #5 baud_clk = ~baud_clk;

  // One bit per baud_clk: start bit, data LSB-first, stop bit.
  always @(posedge baud_clk) begin
    if (rst) begin
      uart_tx_empty <= 1'b1;
      nleft         <= '0;
      tx_line       <= 1'b1;
    end else if (uart_tx_start && !tx_dead) begin
      sh            <= {1'b1, uart_data, 1'b0};
      nleft         <= 4'd10;
      uart_tx_empty <= 1'b0;
    end else if (nleft != 0) begin
      tx_line  <= sh[0];
      rx_frame <= {sh[0], rx_frame[9:1]};
      sh       <= sh >> 1;
      nleft    <= nleft - 4'd1;
      if (nleft == 4'd1) uart_tx_empty <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (req_ready == '0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic held_bad;
    int   n;
    int   e;

    // reset state
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_data", uart_data, 0);
    check("rst_gid", grant_id, 0);
    check("rst_err", err_launch, 0);
    check("rst_start", uart_tx_start, 0);
    check("rst_rts", rts, 0);
`ifdef TX_ARB_FRAME_CNT_EN
    check("rst_fcnt", frame_count, 0);
`endif

    // 1: single frame from req 0
    rst = 1'b0;
    req_valid = 4'b0001;
    req_data  = 32'h0000_00A5;
    #1;
    check("t1_ready", req_ready, 4'b0001);
    check("t1_start0", uart_tx_start, 0);
    tick();
    req_valid = '0;
    #1;
    check("t1_ready_off", req_ready, 0);
    check("t1_start", uart_tx_start, 1);
    check("t1_data", uart_data, 8'hA5);
    check("t1_busy", busy, 1);
    tick();
    check("t1_start_off", uart_tx_start, 0);
    check("t1_tx_busy", uart_tx_empty, 0);
    held_bad = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      if (uart_data !== 8'hA5) held_bad = 1'b1;
      tick();
      n++;
    end
    check("t1_idle", busy, 0);
    check("t1_hold", held_bad, 0);
    check("t1_serial", rx_frame, {1'b1, 8'hA5, 1'b0});

    // 2: all requesting, round-robin from pointer 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    #1;
    for (int f = 0; f < 5; f++) begin
      e = f % 4;
      wait_grant();
      check("t2_ready", req_ready, 1 << e);
      tick();
      check("t2_gid", grant_id, e);
      check("t2_data", uart_data, 8'h11 * (e + 1));
      check("t2_ready_off", req_ready, 0);
    end
    req_valid = '0;
    wait_idle("t2");

    // 3: wrap from pointer 3 (after req 2) to req 0, then req 2
    req_valid = 4'b0100;
    #1;
    check("t3_ready_a", req_ready, 4'b0100);
    tick();
    check("t3_gid_a", grant_id, 2);
    req_valid = 4'b0101;
    wait_grant();
    check("t3_ready_b", req_ready, 4'b0001);
    tick();
    check("t3_gid_b", grant_id, 0);
    wait_grant();
    check("t3_ready_c", req_ready, 4'b0100);
    tick();
    check("t3_gid_c", grant_id, 2);
    req_valid = '0;
    wait_idle("t3");

    // 4: cts holds requesters, mid-frame drop does not abort
    cts = 1'b0;
    req_valid = 4'b0010;
    req_data  = 32'h0000_5C00;
    #1;
    check("t4_ready_hold", req_ready, 0);
    check("t4_rts", rts, 1);
    check("t4_busy", busy, 0);
    tick();
    tick();
    check("t4_start_hold", uart_tx_start, 0);
    check("t4_busy_hold", busy, 0);
    cts = 1'b1;
    #1;
    check("t4_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    check("t4_gid", grant_id, 1);
    check("t4_start", uart_tx_start, 1);
    tick();
    cts = 1'b0;
    wait_idle("t4");
    check("t4_serial", rx_frame, {1'b1, 8'h5C, 1'b0});
    check("t4_rts_off", rts, 0);
    cts = 1'b1;

    // 5: launch timeout
    tx_dead   = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h0000_0077;
    #1;
    check("t5_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    check("t5_err_entry", err_launch, 0);
    tick();
    tick();
    check("t5_err_early", err_launch, 0);
    check("t5_busy_ws", busy, 1);
    tick();
    check("t5_err", err_launch, 1);
    check("t5_idle", busy, 0);
    tx_dead   = 1'b0;
    req_valid = 4'b1000;
    req_data  = 32'h9900_0000;
    #1;
    check("t5_ready_next", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    wait_idle("t5");
    check("t5_err_sticky", err_launch, 1);
    check("t5_serial", rx_frame, {1'b1, 8'h99, 1'b0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_err_clr", err_launch, 0);

    // 6: reset during WAIT_DONE
    req_valid = 4'b0100;
    req_data  = 32'h00AB_0000;
    #1;
    tick();
    req_valid = '0;
    check("t6_gid", grant_id, 2);
    tick();
    tick();
    check("t6_busy_wd", busy, 1);
    rst = 1'b1;
    tick();
    check("t6_busy", busy, 0);
    check("t6_data", uart_data, 0);
    check("t6_gid_rst", grant_id, 0);
    check("t6_start", uart_tx_start, 0);
    check("t6_ready", req_ready, 0);
    check("t6_tx_idle", uart_tx_empty, 1);
    rst = 1'b0;

`ifdef TX_ARB_FRAME_CNT_EN
    req_valid = 4'b1111;
    req_data  = 32'h0403_0201;
    #1;
    for (int f = 0; f < 3; f++) begin
      wait_grant();
      tick();
    end
    req_valid = '0;
    wait_idle("t7");
    check("t7_fcnt", frame_count, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
